bk_seq_wide_adder: RTL
======================

BK_SEQ_WIDE_ADDER -- requirements
Module: bk_seq_wide_adder

Interface
REQ-001 SHALL have parameter NWORDS, default 4, meaning the number of 16-bit words per operand; legal range 1..8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand pair presented.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port in_a  input  16*NWORDS  operand A, unsigned.
REQ-007 SHALL have port in_b  input  16*NWORDS  operand B, unsigned.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port out_sum  output  16*NWORDS+1  A+B, unsigned; MSB is final carry.
REQ-011 SHALL have port busy  output  1  high in CALC state.

Function
REQ-012 SHALL compute the sum word-serially, least-significant word first, using two instances of the existing 16-bit BK_adder (ports a[15:0], b[15:0], s[16:0]; no carry-in).
REQ-013 SHALL form each word as: s1 = A_w + B_w on instance 1; s2 = s1[15:0] + carry_reg on instance 2; result word = s2[15:0]; next carry = s1[16] OR s2[16].
REQ-014 SHALL implement states IDLE, CALC and DONE, with a word index counter of width ceil(log2(NWORDS))+1.
REQ-015 IDLE: in_ready=1; on in_valid AND in_ready, latch in_a/in_b, clear carry_reg and index, clear out_sum, go to CALC.
REQ-016 CALC: in_ready=0, busy=1; each cycle write result word at the current index into out_sum, update carry_reg, increment index.
REQ-017 CALC: on the cycle processing word NWORDS-1, write the final carry into out_sum[16*NWORDS] and go to DONE.
REQ-018 DONE: out_valid=1, in_ready=0; out_sum held stable; on out_ready go to IDLE and drop out_valid on the next edge.
REQ-019 Latency: out_valid SHALL rise exactly NWORDS rising edges after the accepting edge; throughput is one operation per NWORDS+2 cycles when out_ready=1.
REQ-020 in_a/in_b changes after the accepting edge SHALL have no effect on the result in flight.
REQ-021 in_valid asserted in CALC or DONE SHALL be ignored; no operand is latched until in_ready=1.
REQ-022 out_ready asserted outside DONE SHALL be ignored.
REQ-023 out_sum SHALL be the exact (16*NWORDS+1)-bit sum with no truncation; carry SHALL propagate across every word boundary, including a full ripple through all words.
REQ-024 NWORDS=1 SHALL degenerate to a one-cycle CALC with identical handshake rules.

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL enter IDLE; in_ready=1; out_valid=0; busy=0; out_sum=0; carry_reg=0; index=0.
REQ-026 rst asserted mid-CALC or in DONE SHALL abort the operation with no out_valid pulse; the result is discarded.
REQ-027 in_valid sampled on the same edge as rst=1 SHALL NOT be accepted.

Verification
REQ-028 NWORDS=4, A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 -> out_sum=0x1_0000_0000_0000_0000 exactly 4 edges after accept.
REQ-029 NWORDS=4, A=0x0000_0000_0000_FFFF, B=0x1 -> out_sum=0x0_0000_0000_0001_0000; A=0xFFFF, B=123 -> 0x1007A.
REQ-030 Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_a/in_valid -> out_sum unchanged, in_ready=0, no new accept; out_ready=1 -> IDLE next edge.
REQ-031 Reset mid-operation: rst=1 on the second CALC cycle -> next edge out_sum=0, out_valid=0, in_ready=1; next operation A=3, B=4 -> out_sum=7.
REQ-032 Random: 1000 vectors at NWORDS=4 and NWORDS=1, random in_valid/out_ready gaps -> every out_sum equals reference A+B, one result per accept, zero errors reported.

Source files
------------

// File: rtl/bk_seq_wide_adder.sv
// Word-serial wide adder: adds two NWORDS x 16-bit operands one 16-bit word
// per cycle, least-significant word first, using two 16-bit Brent-Kung adders
// (operand add, then carry-in add). Valid/ready handshake on both sides.

// 16-bit Brent-Kung prefix adder, no carry-in; s[16] is the carry out.
module BK_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [16:0] s
);
    logic [15:0] p0;
    logic [15:0] g;
    logic [15:0] p;

    // Up-sweep builds group generate/propagate at power-of-two spans,
    // down-sweep fills in the remaining prefix positions.
    always_comb begin
        p0 = a ^ b;
        g  = a & b;
        p  = p0;
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 16; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    g[i] = g[i] | (p[i] & g[(i >= (1 << l)) ? i - (1 << l) : 0]);
                    p[i] = p[i] & p[(i >= (1 << l)) ? i - (1 << l) : 0];
                end
            end
        end
        for (int l = 2; l >= 0; l--) begin
            for (int i = 0; i < 16; i++) begin
                if (i >= (3 << l) - 1 && ((i + 1 - (1 << l)) % (2 << l)) == 0) begin
                    g[i] = g[i] | (p[i] & g[(i >= (1 << l)) ? i - (1 << l) : 0]);
                    p[i] = p[i] & p[(i >= (1 << l)) ? i - (1 << l) : 0];
                end
            end
        end
        s     = '0;
        s[0]  = p0[0];
        for (int i = 1; i < 16; i++) s[i] = p0[i] ^ g[i-1];
        s[16] = g[15];
    end
endmodule

module bk_seq_wide_adder #(
    parameter int NWORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*NWORDS-1:0] in_a,
    input  logic [16*NWORDS-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*NWORDS:0]   out_sum,
    output logic                 busy
);
    localparam int W  = 16 * NWORDS;
    localparam int IW = $clog2(NWORDS) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic           carry_reg;
    logic [IW-1:0]  idx;
    logic [31:0]    base;
    logic [15:0]    a_w;
    logic [15:0]    b_w;
    logic [16:0]    s1;
    logic [16:0]    s2;
    logic           carry_nxt;
    logic           last;

    assign base      = {{(32-IW){1'b0}}, idx} << 4;
    assign a_w       = a_reg[base +: 16];
    assign b_w       = b_reg[base +: 16];
    assign last      = (idx == IW'(NWORDS - 1));
    // At most one of the two partial adds can carry out, so OR is exact.
    assign carry_nxt = s1[16] | s2[16];

    BK_adder u_add_ab (.a(a_w),       .b(b_w),                .s(s1));
    BK_adder u_add_c  (.a(s1[15:0]),  .b({15'd0, carry_reg}), .s(s2));

    // Handshake FSM with registered status outputs and per-word result writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_sum   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        carry_reg <= 1'b0;
                        idx       <= '0;
                        out_sum   <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    out_sum[base +: 16] <= s2[15:0];
                    carry_reg           <= carry_nxt;
                    idx                 <= idx + 1'b1;
                    if (last) begin
                        out_sum[W] <= carry_nxt;
                        busy       <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
